mem_bram_bridge: RTL and testbench

//  Core-to-BRAM bridge for the instruction and data memory ports. Successor to the single-outstanding instruction-BRAM glue.

---
 rtl/mem_bram_bridge_pkg.sv | 20 ++
 rtl/bridge_rsp_fifo.sv | 43 ++++
 rtl/mem_bram_bridge.sv | 123 ++++++++++++
 tb/tb_mem_bram_bridge.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bram_bridge_pkg.sv
// rtl/mem_bram_bridge_pkg.sv - shared response-entry layout and latency-pipe stage type
package mem_bram_bridge_pkg;

  // Response entry is {err, data}; errors and write responses carry ERR_DATA.
  localparam int          RSP_DATA_W = 32;
  localparam logic [31:0] ERR_DATA   = 32'h0;

  typedef struct packed {
    logic                  err;
    logic [RSP_DATA_W-1:0] data;
  } rsp_entry_t;

  // One slot of the BRAM latency shift register.
  typedef struct packed {
    logic valid;
    logic is_write;
    logic err;
  } pipe_stage_t;

endpackage

// File: rtl/bridge_rsp_fifo.sv
// rtl/bridge_rsp_fifo.sv - synchronous first-word-fall-through response FIFO
module bridge_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  // Extra pointer bit distinguishes full from empty when the indices match.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; push and pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_bram_bridge.sv
// rtl/mem_bram_bridge.sv - pipelined OBI-style core-to-BRAM bridge with credit-limited outstanding responses
module mem_bram_bridge
  import mem_bram_bridge_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_DEPTH = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                BRAM_LAT  = 1,
  parameter int                RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              bram_en_o,
  output logic [3:0]        bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [DATA_W-1:0] bram_din_o,
  input  logic [DATA_W-1:0] bram_dout_i
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              oow;
  logic [ADDR_W-1:0] offset;
  pipe_stage_t       pipe [BRAM_LAT];
  pipe_stage_t       pipe_exit;
  logic              pipe_exit_valid;
  rsp_entry_t        exit_entry;
  rsp_entry_t        head_entry;
  logic [DATA_W:0]   fifo_head;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_push;
  logic              fifo_pop;

  // Credits cover both in-flight pipe slots and FIFO entries, so the FIFO can never overflow.
  assign gnt_o  = req_i && (cnt < CNT_W'(RSP_DEPTH)) && !rstb;
  assign accept = req_i && gnt_o;

  // Address decode: below the base or past the last word is out of window.
  assign offset = addr_i - BASE_ADDR;
  assign oow    = (addr_i < BASE_ADDR) || ((offset >> 2) >= ADDR_W'(MEM_DEPTH));

  assign bram_en_o   = accept && !oow;
  assign bram_we_o   = (bram_en_o && we_i) ? be_i : 4'b0000;
  assign bram_addr_o = offset;
  assign bram_din_o  = wdata_i;

  // Latency pipe: tags each accepted request so its response lines up with bram_dout_i.
  always_ff @(posedge clk) begin
    if (rstb) begin
      for (int i = 0; i < BRAM_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {accept, we_i, oow};
      for (int i = 1; i < BRAM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign pipe_exit       = pipe[BRAM_LAT-1];
  assign pipe_exit_valid = pipe_exit.valid;

  // Build the response for the transaction leaving the pipe; only reads carry BRAM data.
  always_comb begin
    exit_entry.err  = pipe_exit.err;
    exit_entry.data = (pipe_exit.err || pipe_exit.is_write) ? ERR_DATA : bram_dout_i;
  end

  // Bypass the FIFO only when it is empty and the core takes the response now.
  assign fifo_push  = pipe_exit_valid && !(fifo_empty && rready_i);
  assign fifo_pop   = !fifo_empty && rready_i;
  assign head_entry = fifo_head;

  bridge_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_rsp_fifo (
    .clk       (clk),
    .rstb      (rstb),
    .push      (fifo_push),
    .push_data (exit_entry),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Response mux: the FIFO head is older than the pipe exit, so it always goes first.
  always_comb begin
    rvalid_o = 1'b0;
    rdata_o  = '0;
    err_o    = 1'b0;
    if (!rstb) begin
      if (!fifo_empty) begin
        rvalid_o = 1'b1;
        rdata_o  = head_entry.data;
        err_o    = head_entry.err;
      end else if (pipe_exit_valid) begin
        rvalid_o = 1'b1;
        rdata_o  = exit_entry.data;
        err_o    = exit_entry.err;
      end
    end
  end

  // Credit counter: one up per accept, one down per response handshake.
  always_ff @(posedge clk) begin
    if (rstb) cnt <= '0;
    else      cnt <= cnt + CNT_W'(accept) - CNT_W'(rvalid_o && rready_i);
  end

endmodule

// File: tb/tb_mem_bram_bridge.sv
// tb/tb_mem_bram_bridge.sv - directed self-checking bench for mem_bram_bridge at BRAM_LAT 1 and 2
module tb_mem_bram_bridge;

  logic        clk    = 1'b0;
  logic        rstb   = 1'b1;
  logic        sel    = 1'b0;
  logic        req    = 1'b0;
  logic        we     = 1'b0;
  logic        rready = 1'b1;
  logic [31:0] addr   = '0;
  logic [31:0] wdata  = '0;
  logic [3:0]  be     = '0;

  wire req1 = req & ~sel;
  wire req2 = req & sel;

  logic        gnt1, rv1, er1, en1, gnt2, rv2, er2, en2;
  logic [31:0] rd1, ba1, din1, dout1, rd2, ba2, din2, dout2;
  logic [3:0]  bw1, bw2;

  int checks = 0;
  int errors = 0;
  int k, idx;
  logic granted;

  logic [31:0] t5_addr [4] = '{32'h0, 32'h4, 32'h3FFC, 32'h4000};
  logic [31:0] t5_data [4] = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0FFF, 32'h0};
  logic        t5_err  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  mem_bram_bridge #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(4096), .BASE_ADDR(32'h0), .BRAM_LAT(1), .RSP_DEPTH(4)
  ) u_dut1 (
    .clk(clk), .rstb(rstb), .req_i(req1), .gnt_o(gnt1), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rvalid_o(rv1), .rready_i(rready), .rdata_o(rd1), .err_o(er1),
    .bram_en_o(en1), .bram_we_o(bw1), .bram_addr_o(ba1), .bram_din_o(din1), .bram_dout_i(dout1)
  );

  mem_bram_bridge #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(4096), .BASE_ADDR(32'h0), .BRAM_LAT(2), .RSP_DEPTH(4)
  ) u_dut2 (
    .clk(clk), .rstb(rstb), .req_i(req2), .gnt_o(gnt2), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rvalid_o(rv2), .rready_i(rready), .rdata_o(rd2), .err_o(er2),
    .bram_en_o(en2), .bram_we_o(bw2), .bram_addr_o(ba2), .bram_din_o(din2), .bram_dout_i(dout2)
  );

  // Behavioural BRAMs preloaded with word i = 0x1000_0000 + i; read-first, byte-enabled writes.
  logic [31:0] mem1 [4096];
  logic [31:0] mem2 [4096];
  logic [31:0] m2_s1;
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) begin
        mem1[i] <= 32'h1000_0000 + 32'(i);
        mem2[i] <= 32'h1000_0000 + 32'(i);
      end
      loaded <= 1'b1;
    end else begin
      if (en1) begin
        for (int b = 0; b < 4; b++) if (bw1[b]) mem1[ba1[13:2]][8*b +: 8] <= din1[8*b +: 8];
        dout1 <= mem1[ba1[13:2]];
      end
      if (en2) begin
        for (int b = 0; b < 4; b++) if (bw2[b]) mem2[ba2[13:2]][8*b +: 8] <= din2[8*b +: 8];
        m2_s1 <= mem2[ba2[13:2]];
      end
      dout2 <= m2_s1;
    end
  end

  logic        g, rv, er, en;
  logic [31:0] rd, ba;
  logic [3:0]  bw;

  always_comb begin
    g  = sel ? gnt2 : gnt1;
    rv = sel ? rv2  : rv1;
    er = sel ? er2  : er1;
    en = sel ? en2  : en1;
    rd = sel ? rd2  : rd1;
    ba = sel ? ba2  : ba1;
    bw = sel ? bw2  : bw1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rstb) begin
      chk("inv_full_exit1", 32'(u_dut1.fifo_full && u_dut1.pipe_exit_valid), 32'h0);
      chk("inv_full_exit2", 32'(u_dut2.fifo_full && u_dut2.pipe_exit_valid), 32'h0);
    end
  end

  initial begin
    rstb = 1'b1; sel = 1'b0; req = 1'b1; addr = 32'h8;
    tick(); tick();
    @(negedge clk);
    chk("rst_gnt", g, 0); chk("rst_rvalid", rv, 0); chk("rst_rdata", rd, 0);
    chk("rst_err", er, 0); chk("rst_en", en, 0); chk("rst_we", bw, 0);
    tick();
    req = 1'b0; rstb = 1'b0;

    // 1: single read, LAT 1
    rready = 1'b1; req = 1'b1; we = 1'b0; addr = 32'h8;
    @(negedge clk);
    chk("t1_gnt", g, 1); chk("t1_en", en, 1); chk("t1_addr", ba, 32'h8); chk("t1_rv_early", rv, 0);
    tick(); req = 1'b0;
    @(negedge clk);
    chk("t1_rvalid", rv, 1); chk("t1_rdata", rd, 32'h1000_0002); chk("t1_err", er, 0);
    tick();

    // 2: back-to-back reads, LAT 2
    sel = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req = (c < 4); addr = 32'(4 * c);
      @(negedge clk);
      if (c < 4) chk("t2_gnt", g, 1);
      chk("t2_rvalid", rv, 32'(c >= 2 && c < 6));
      if (c >= 2 && c < 6) chk("t2_rdata", rd, 32'h1000_0000 + 32'(c - 2));
      tick();
    end
    req = 1'b0;

    // 3: back-pressure fills credits, then drains in order
    rready = 1'b0; k = 0;
    for (int c = 0; c < 8; c++) begin
      req = (k < 6); addr = 32'h20 + 32'(4 * k);
      @(negedge clk);
      granted = g;
      if (c >= 2) begin chk("t3_hold_rv", rv, 1); chk("t3_hold_rdata", rd, 32'h1000_0008); end
      if (c == 7) chk("t3_gnt_low", g, 0);
      tick();
      if (granted) k++;
    end
    chk("t3_grants", k, 4);
    rready = 1'b1; idx = 0;
    for (int c = 0; c < 30 && idx < 6; c++) begin
      req = (k < 6); addr = 32'h20 + 32'(4 * k);
      @(negedge clk);
      granted = g;
      if (rv) begin
        chk("t3_rdata", rd, 32'h1000_0008 + 32'(idx)); chk("t3_err", er, 0);
        idx++;
      end
      tick();
      if (granted) k++;
    end
    req = 1'b0;
    chk("t3_rsp_count", idx, 6); chk("t3_grants_total", k, 6);

    // 4: partial write then read back, LAT 1
    sel = 1'b0; req = 1'b1; we = 1'b1; addr = 32'h10; be = 4'b0011; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("t4_wr_gnt", g, 1); chk("t4_bram_we", bw, 4'b0011);
    tick();
    we = 1'b0; be = 4'b0000;
    @(negedge clk);
    chk("t4_rd_bram_we", bw, 0); chk("t4_wr_rv", rv, 1); chk("t4_wr_rdata", rd, 0); chk("t4_wr_err", er, 0);
    tick();
    req = 1'b0;
    @(negedge clk);
    chk("t4_rd_rv", rv, 1); chk("t4_rd_rdata", rd, 32'h1000_A5A5); chk("t4_rd_err", er, 0);
    tick();

    // 5: last in-window word and first out-of-window word, LAT 1
    for (int c = 0; c < 5; c++) begin
      req = (c < 4);
      if (c < 4) addr = t5_addr[c];
      @(negedge clk);
      if (c < 4) begin chk("t5_gnt", g, 1); chk("t5_en", en, 32'(c < 3)); end
      if (c > 0) begin
        chk("t5_rv", rv, 1); chk("t5_rdata", rd, t5_data[c-1]); chk("t5_err", er, 32'(t5_err[c-1]));
      end
      tick();
    end
    req = 1'b0;

    // 6: reset with reads outstanding, LAT 2
    sel = 1'b1; rready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req = 1'b1; addr = 32'h30 + 32'(4 * c);
      @(negedge clk);
      chk("t6_gnt_pre", g, 1);
      tick();
    end
    req = 1'b0; rstb = 1'b1;
    @(negedge clk);
    chk("t6_rv_in_rst", rv, 0);
    tick();
    rstb = 1'b0; rready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req = (c == 0); addr = 32'h14;
      @(negedge clk);
      if (c == 0) chk("t6_gnt", g, 1);
      chk("t6_rvalid", rv, 32'(c == 2));
      if (c == 2) chk("t6_rdata", rd, 32'h1000_0005);
      tick();
    end
    req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
